// File: rtl/egress_stats.sv
// egress_stats: per-flow (src,dest) packet/length/latency statistics with
// a RAM-backed counter set, a 16-cycle clear walk and a 2-cycle read port.
// Ports: clk, reset (sync, active-high); meta_valid/meta_in record input
// (dest[31:30] src[29:28] len[27:22] t_delta[21:0]); clear pulse;
// chipselect/read/address software read; readdata/readdatavalid; busy.
// Optional feature macro: EGRESS_STATS_LATMAX_EN (stores lat_max field).
module egress_stats #(
    parameter int PORT_CNT  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        meta_valid,
    input  logic [31:0] meta_in,
    input  logic        clear,
    input  logic        chipselect,
    input  logic        read,
    input  logic [6:0]  address,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        busy
);

    localparam int ENTRIES = PORT_CNT * PORT_CNT;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CW      = CNT_WIDTH;
`ifdef EGRESS_STATS_LATMAX_EN
    localparam int FIELDS  = 4;
`else
    localparam int FIELDS  = 3;
`endif
    localparam int ENT_W   = FIELDS * CW;

    typedef logic [CW-1:0]    cnt_t;
    typedef logic [ENT_W-1:0] ent_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    function automatic cnt_t sat_add(input cnt_t a, input cnt_t b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? '1 : s[CW-1:0];
    endfunction

    state_t     state_q, state_d;
    idx_t       clr_idx_q, clr_idx_d;
    ent_t       ram_q [ENTRIES];
    ent_t       rd_data_q, rd_data_d;
    logic       s1_valid_q, s1_valid_d;
    idx_t       s1_idx_q, s1_idx_d;
    cnt_t       s1_len_q, s1_len_d;
    cnt_t       s1_td_q, s1_td_d;
    logic       fwd_valid_q, fwd_valid_d;
    ent_t       fwd_data_q, fwd_data_d;
    cnt_t       total_q, total_d;
    cnt_t       dropped_q, dropped_d;
    logic       pend_q, pend_d;
    logic [6:0] pend_addr_q, pend_addr_d;
    logic       sw_q, sw_d;
    logic       sw_glob_q, sw_glob_d;
    logic [1:0] sw_fld_q, sw_fld_d;
    cnt_t       glob_q, glob_d;
    logic [31:0] readdata_q, readdata_d;
    logic       rdv_q, rdv_d;

    logic       run, first, s0_acc, s1_we, sw_want, sw_issue;
    idx_t       s0_idx, rd_addr;
    logic [6:0] sw_addr;
    ent_t       base, s1_res;
    cnt_t       field, dbase;
    logic       ram_we;
    idx_t       ram_waddr;
    ent_t       ram_wdata;

    always_comb begin
        run    = (state_q == ST_RUN);
        first  = !run && (clr_idx_q == '0);
        s0_acc = meta_valid && run;
        s0_idx = idx_t'({meta_in[29:28], meta_in[31:30]});
        // A clear landing on an S1 record drops that write.
        s1_we  = s1_valid_q && run && !clear;

        // Previous record to the same entry wrote after our RAM read.
        base = fwd_valid_q ? fwd_data_q : rd_data_q;
        s1_res = '0;
        s1_res[0+:CW]    = sat_add(base[0+:CW], cnt_t'(1));
        s1_res[CW+:CW]   = sat_add(base[CW+:CW], s1_len_q);
        s1_res[2*CW+:CW] = sat_add(base[2*CW+:CW], s1_td_q);
`ifdef EGRESS_STATS_LATMAX_EN
        s1_res[3*CW+:CW] = (s1_td_q > base[3*CW+:CW]) ?
                           s1_td_q : base[3*CW+:CW];
`endif

        // One software read outstanding; records own the read port.
        sw_want  = pend_q || (chipselect && read && !sw_q);
        sw_addr  = pend_q ? pend_addr_q : address;
        sw_issue = sw_want && run && !s0_acc;
        pend_d      = sw_want && !sw_issue;
        pend_addr_d = sw_addr;
        sw_d        = sw_issue;
        sw_glob_d   = sw_issue ? sw_addr[6] : sw_glob_q;
        sw_fld_d    = sw_issue ? sw_addr[1:0] : sw_fld_q;
        glob_d      = sw_addr[0] ? dropped_q : total_q;

        rd_addr   = s0_acc ? s0_idx : sw_addr[2+:IDX_W];
        rd_data_d = ram_q[rd_addr];

        s1_valid_d  = s0_acc;
        s1_idx_d    = s0_acc ? s0_idx : s1_idx_q;
        s1_len_d    = s0_acc ? cnt_t'(meta_in[27:22]) : s1_len_q;
        s1_td_d     = s0_acc ? cnt_t'(meta_in[21:0]) : s1_td_q;
        fwd_valid_d = s0_acc && s1_we && (s1_idx_q == s0_idx);
        fwd_data_d  = s1_res;

        total_d = first ? '0 :
                  (s1_we ? sat_add(total_q, cnt_t'(1)) : total_q);
        dbase     = first ? '0 : dropped_q;
        dropped_d = (meta_valid && !run) ?
                    sat_add(dbase, cnt_t'(1)) : dbase;

        field = '0;
        if (sw_glob_q) begin
            field = glob_q;
        end else begin
            case (sw_fld_q)
                2'd0: field = rd_data_q[0+:CW];
                2'd1: field = rd_data_q[CW+:CW];
                2'd2: field = rd_data_q[2*CW+:CW];
`ifdef EGRESS_STATS_LATMAX_EN
                2'd3: field = rd_data_q[3*CW+:CW];
`endif
                default: field = '0;
            endcase
        end
        rdv_d      = sw_q;
        readdata_d = sw_q ? 32'(field) : readdata_q;
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ram_we    = 1'b0;
        ram_waddr = s1_idx_q;
        ram_wdata = s1_res;
        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_idx_q;
                ram_wdata = '0;
                if (clear) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == idx_t'(ENTRIES - 1)) begin
                    state_d   = ST_RUN;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + idx_t'(1);
                end
            end
            default: begin
                ram_we = s1_we;
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_waddr] <= ram_wdata;
        rd_data_q <= rd_data_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_len_q    <= '0;
            s1_td_q     <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            total_q     <= '0;
            dropped_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            sw_q        <= 1'b0;
            sw_glob_q   <= 1'b0;
            sw_fld_q    <= '0;
            glob_q      <= '0;
            readdata_q  <= '0;
            rdv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_len_q    <= s1_len_d;
            s1_td_q     <= s1_td_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            total_q     <= total_d;
            dropped_q   <= dropped_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            sw_q        <= sw_d;
            sw_glob_q   <= sw_glob_d;
            sw_fld_q    <= sw_fld_d;
            glob_q      <= glob_d;
            readdata_q  <= readdata_d;
            rdv_q       <= rdv_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;
    assign busy          = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_egress_stats.sv
// tb_egress_stats: randomized and directed checks of egress_stats against
// a per-flow counter model; honours EGRESS_STATS_LATMAX_EN like the DUT.
module tb_egress_stats;

    logic        clk = 1'b0;
    logic        reset, meta_valid, clear, chipselect, read;
    logic [31:0] meta_in;
    logic [6:0]  address;
    logic [31:0] readdata;
    logic        readdatavalid, busy;

    always #5 clk = ~clk;

    egress_stats dut (
        .clk(clk), .reset(reset), .meta_valid(meta_valid),
        .meta_in(meta_in), .clear(clear), .chipselect(chipselect),
        .read(read), .address(address), .readdata(readdata),
        .readdatavalid(readdatavalid), .busy(busy)
    );

    localparam longint SAT = 64'hFFFF_FFFF;

    int n_tests = 0;
    int n_fail  = 0;

    longint m_pkt[16], m_len[16], m_lat[16], m_max[16];
    longint m_total, m_drop;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        return (x > SAT) ? SAT : x;
    endfunction

    function automatic void m_clear();
        for (int e = 0; e < 16; e++) begin
            m_pkt[e] = 0; m_len[e] = 0; m_lat[e] = 0; m_max[e] = 0;
        end
        m_total = 0;
        m_drop  = 0;
    endfunction

    function automatic void m_rec(input int e, input int len, input int td);
        m_pkt[e] = sat(m_pkt[e] + 1);
        m_len[e] = sat(m_len[e] + len);
        m_lat[e] = sat(m_lat[e] + td);
        if (td > m_max[e]) m_max[e] = td;
        m_total = sat(m_total + 1);
    endfunction

    function automatic longint m_field(input int e, input int f);
        case (f)
            0: return m_pkt[e];
            1: return m_len[e];
            2: return m_lat[e];
`ifdef EGRESS_STATS_LATMAX_EN
            default: return m_max[e];
`else
            default: return 0;
`endif
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one record for one cycle; meta_valid stays high afterwards.
    task automatic send(input logic [1:0] s, input logic [1:0] d,
                        input logic [5:0] len, input logic [21:0] td,
                        input bit dropped);
        meta_in    = {d, s, len, td};
        meta_valid = 1'b1;
        tick();
        if (dropped) m_drop = sat(m_drop + 1);
        else m_rec(int'({s, d}), int'(len), int'(td));
    endtask

    task automatic idle(input int n);
        meta_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic sw_read(input logic [6:0] a, output logic [31:0] d,
                           output int lat);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        d   = 32'hDEAD_BEEF;
        lat = -1;
        for (int i = 1; i <= 5; i++) begin
            if (readdatavalid && lat < 0) begin
                d   = readdata;
                lat = i;
            end
            tick();
        end
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a,
                          input longint exp);
        logic [31:0] d;
        int lat;
        sw_read(a, d, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk(tag, 64'(d), exp);
    endtask

    task automatic check_all(input string tag);
        for (int e = 0; e < 16; e++)
            for (int f = 0; f < 4; f++)
                rd_chk($sformatf("%s_e%0d_f%0d", tag, e, f),
                       7'(e * 4 + f), m_field(e, f));
        rd_chk({tag, "_total"}, 7'h40, m_total);
        rd_chk({tag, "_drop"}, 7'h41, m_drop);
    endtask

    task automatic wait_idle(input string tag, input int already);
        int n;
        n = already;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd16);
    endtask

    // Clear pulse, then ndrop records offered while the walk runs.
    task automatic do_clear(input string tag, input int ndrop);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_clear();
        for (int i = 0; i < ndrop; i++)
            send(2'(i), 2'(i + 1), 6'd7, 22'd50, 1'b1);
        meta_valid = 1'b0;
        wait_idle(tag, ndrop);
    endtask

    initial begin
        int rdv_cnt, rdv_cyc;
        reset      = 1'b1;
        meta_valid = 1'b0;
        meta_in    = '0;
        clear      = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        address    = '0;
        m_clear();
        repeat (3) tick();
        chk("rst_readdata", 64'(readdata), 64'd0);
        chk("rst_rdv", 64'(readdatavalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        wait_idle("rst", 0);
        check_all("rst");

        send(2'd1, 2'd2, 6'd10, 22'd100, 1'b0);
        idle(1);
        rd_chk("one_pkt", 7'd24, 1);
        rd_chk("one_len", 7'd25, 10);
        rd_chk("one_lat", 7'd26, 100);
`ifdef EGRESS_STATS_LATMAX_EN
        rd_chk("one_max", 7'd27, 100);
`else
        rd_chk("one_max", 7'd27, 0);
`endif
        rd_chk("one_total", 7'h40, 1);

        do_clear("b2b", 0);
        send(2'd1, 2'd2, 6'd1, 22'd5, 1'b0);
        send(2'd1, 2'd2, 6'd1, 22'd9, 1'b0);
        send(2'd1, 2'd2, 6'd1, 22'd3, 1'b0);
        send(2'd1, 2'd2, 6'd1, 22'd7, 1'b0);
        send(2'd1, 2'd2, 6'd1, 22'd1, 1'b0);
        idle(1);
        rd_chk("b2b_pkt", 7'd24, 5);
        rd_chk("b2b_lat", 7'd26, 25);
`ifdef EGRESS_STATS_LATMAX_EN
        rd_chk("b2b_max", 7'd27, 9);
`else
        rd_chk("b2b_max", 7'd27, 0);
`endif

        // 20 record cycles, read at cycle 3, ignored second read at 6.
        rdv_cnt = 0;
        rdv_cyc = -1;
        for (int k = 0; k < 36; k++) begin
            logic [31:0] r;
            r = $urandom;
            meta_valid = (k < 20);
            meta_in    = r;
            chipselect = (k == 3 || k == 6);
            read       = chipselect;
            address    = 7'h40;
            tick();
            if (k < 20) m_rec(int'({r[29:28], r[31:30]}),
                              int'(r[27:22]), int'(r[21:0]));
            if (readdatavalid) begin
                rdv_cnt++;
                rdv_cyc = k + 1;
            end
        end
        chipselect = 1'b0;
        read       = 1'b0;
        chk("stall_rdv_count", 64'(rdv_cnt), 64'd1);
        chk("stall_rdv_cycle", 64'(rdv_cyc), 64'd22);
        check_all("stall");

        do_clear("sat", 0);
        for (int i = 0; i < 1024; i++)
            send(2'd0, 2'd0, 6'd0, 22'h3FFFFF, 1'b0);
        send(2'd0, 2'd0, 6'd0, 22'h3F0, 1'b0);
        idle(1);
        rd_chk("sat_pre", 7'd2, 64'hFFFF_FFF0);
        send(2'd0, 2'd0, 6'd0, 22'h20, 1'b0);
        idle(1);
        rd_chk("sat_lat", 7'd2, 64'hFFFF_FFFF);
        check_all("sat");

        do_clear("rnd", 0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (r[31:30] == 2'd0) idle(1);
            send(r[1:0], r[3:2], r[9:4], 22'($urandom_range(0, 4000)),
                 1'b0);
        end
        idle(1);
        check_all("rnd");

        do_clear("drop", 3);
        check_all("drop");

        // Reset with a read in flight: no strobe may appear.
        send(2'd3, 2'd3, 6'd4, 22'd4, 1'b0);
        idle(1);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 7'h40;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        reset      = 1'b1;
        rdv_cnt    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (readdatavalid) rdv_cnt++;
        end
        chk("rst_mid_rdv", 64'(rdv_cnt), 64'd0);
        reset = 1'b0;
        m_clear();
        wait_idle("rst_mid", 0);
        rd_chk("rst_mid_e15", 7'd60, 0);
        rd_chk("rst_mid_total", 7'h40, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/egress_stats.md
# egress_stats

Per-flow statistics collector sitting directly downstream of the egress metadata buffer. It consumes one 32-bit metadata record per `meta_valid` strobe and updates a RAM-backed counter set for the record's (src, dest) pair. The counters are packet count, length sum, latency sum and latency maximum. Software reads the counters through an addressed read port with fixed latency.

## Interface
Parameters:
- `PORT_CNT`, 4: switch ports; pair index = {src, dest}, `PORT_CNT*PORT_CNT` = 16 entries.
- `CNT_WIDTH`, 32: width of every counter.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `meta_valid` in 1: one record per cycle when high.
- `meta_in` in 32: record; dest [31:30], src [29:28], len [27:22], t_delta [21:0].
- `clear` in 1: pulse; zeroes all statistics.
- `chipselect` in 1: software access select.
- `read` in 1: read strobe, qualified by `chipselect`.
- `address` in 7: register address.
- `readdata` out 32: read result.
- `readdatavalid` out 1: one-cycle strobe marking `readdata` valid.
- `busy` out 1: clear walk in progress.

## Operation
- Entry RAM: 16 entries, one write port and one read port, 1-cycle read latency. Each entry holds `pkt_cnt`, `len_sum`, `lat_sum` and, when configured, `lat_max`.
- Address map:
  - `address[6]=0`: entry `address[5:2]`, field `address[1:0]` (0 pkt_cnt, 1 len_sum, 2 lat_sum, 3 lat_max).
  - `address[6]=1`: `address[0]=0` selects `total_pkts`, `address[0]=1` selects `dropped`; other bits are ignored.
- State machine:
  - CLEAR: writes zero to entries 0..15 on consecutive cycles, drives `busy=1`, then moves to RUN.
  - RUN: normal operation.
  - Reset enters CLEAR. A `clear` pulse seen in RUN enters CLEAR on the next cycle. `clear` during CLEAR restarts the walk from entry 0.
- Record accept, RUN only:
  - S0 (cycle t): latch the record and issue a RAM read of the entry.
  - S1 (cycle t+1): compute the update and write it back.
- Update arithmetic, all saturating at all-ones with zero-extended operands:
  - `pkt_cnt+1`
  - `len_sum+len`
  - `lat_sum+t_delta`
  - `lat_max=max(lat_max,t_delta)`
  - `total_pkts+1`
- Forwarding: if the S1 entry equals the entry now in S0, S0 uses the S1 result, not the stale RAM data. Back-to-back records to one pair must count exactly.
- `meta_valid` while `busy`: the record is discarded and `dropped` increments, saturating.
- CLEAR zeroes `total_pkts` and `dropped` in its first cycle.
- Software read:
  - Accepted when `chipselect&read`, the RAM read port is free (no record in S0) and state is RUN.
  - Otherwise the read is held pending and issued on the first free cycle.
  - Only one read is outstanding at a time; further reads while one is pending or in flight are ignored.
  - Reads during CLEAR stay pending until RUN.
- Global registers are returned with the same latency as entry reads.

## Timing
- Reset values: `readdata=0`, `readdatavalid=0`, `busy=1`. `busy` falls 16 cycles after the first cycle with `reset` low.
- Record accepted at t: its entry is readable by a software read accepted at t+2 or later. `total_pkts` updates at the t+1 edge.
- Throughput: one record per cycle sustained; no backpressure.
- Read accepted at t gives `readdata` and `readdatavalid` at t+2; `readdatavalid` stays high for exactly 1 cycle.
- Simultaneous `meta_valid` and read: the record wins and the read is delayed by the number of contiguous record cycles.
- `clear` concurrent with a record in S1: that write is dropped and CLEAR zeroes everything.
- `reset` mid-operation: pending and in-flight reads are abandoned with no `readdatavalid`, and CLEAR restarts.

## Configuration
- `EGRESS_STATS_LATMAX_EN`
  - Defined: `lat_max` is stored, updated and cleared; field 3 returns it.
  - Undefined: the RAM entry omits `lat_max` (96 bits) and field 3 reads 0.

## Test plan
- Reset, then poll: `busy` high for 16 cycles after reset release; all 16×3 fields, `total_pkts` and `dropped` read 0.
- Single record src=1, dest=2, len=10, t_delta=100: entry 6 reads pkt_cnt=1, len_sum=10, lat_sum=100, lat_max=100 (0 without macro); `total_pkts`=1.
- Five back-to-back records to entry 6 with t_delta 5,9,3,7,1: pkt_cnt=5, lat_sum=25, lat_max=9 (forwarding check).
- Record every cycle for 20 cycles with a read issued at cycle 3: `readdatavalid` exactly once, 2 cycles after the last record; a second read issued while pending yields no extra strobe.
- Preload entry 0 `lat_sum`=0xFFFFFFF0, then add t_delta=0x20: `lat_sum`=0xFFFFFFFF.
- `clear` pulse followed by 3 records during `busy`: `dropped`=3, all entries 0, `total_pkts`=0 after `busy` falls.
